shift_reg_univ: RTL and testbench

//   Parametrised universal register: the successor to the single-bit D flip-flop.

---
 rtl/shift_reg_univ.sv | 109 ++++++++++
 tb/tb_shift_reg_univ.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_univ.sv
// shift_reg_univ: WIDTH-bit universal register (hold / shift right / shift left /
// parallel load) with clock enable. It counts shifts since the last load or reset.
// Full is a level that shows a whole word has been shifted out.
// Done is a one-cycle pulse on the shift that brings the count up to WIDTH.
// Optional build macro: SHREG_ROTATE_EN. When it is defined, the shifts rotate
// the register and the serial inputs are ignored.
module shift_reg_univ #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             En,
    input  logic [1:0]       Mode,
    input  logic [WIDTH-1:0] D,
    input  logic             SerMSB,
    input  logic             SerLSB,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qbar,
    output logic             SoutLSB,
    output logic             SoutMSB,
    output logic             Full,
    output logic             Done
);

    localparam int             CW      = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(WIDTH);
    localparam logic [CW-1:0]  CNT_ONE = CW'(1);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_RIGHT = 2'b01;
    localparam logic [1:0] MODE_LEFT  = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             msb_in, lsb_in;
    logic             is_shift;

`ifdef SHREG_ROTATE_EN
    // Rotation: the bit that leaves the register comes back in at the other end
    always_comb begin
        msb_in = q_q[0];
        lsb_in = q_q[WIDTH-1];
    end
`else
    // Serial inputs feed the vacated end of the register
    always_comb begin
        msb_in = SerMSB;
        lsb_in = SerLSB;
    end
`endif

    // Next-state logic. Shifts count in either direction, and the count saturates at WIDTH.
    always_comb begin
        q_d      = q_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        is_shift = 1'b0;
        if (En) begin
            case (Mode)
                MODE_HOLD:  q_d = q_q;
                MODE_RIGHT: begin
                    q_d      = {msb_in, q_q[WIDTH-1:1]};
                    is_shift = 1'b1;
                end
                MODE_LEFT:  begin
                    q_d      = {q_q[WIDTH-2:0], lsb_in};
                    is_shift = 1'b1;
                end
                MODE_LOAD:  begin
                    q_d   = D;
                    cnt_d = '0;
                end
                default:    q_d = q_q;
            endcase
            if (is_shift && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + CNT_ONE;
                // Done fires only on the WIDTH-1 -> WIDTH transition, never while saturated
                done_d = (cnt_q == (CNT_MAX - CNT_ONE));
            end
        end
    end

    // State registers. Reset has priority over the enable and every mode.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            q_q    <= RESET_VAL;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    // Outputs derived from the registers without any extra delay
    always_comb begin
        Q       = q_q;
        Qbar    = ~q_q;
        SoutLSB = q_q[0];
        SoutMSB = q_q[WIDTH-1];
        Full    = (cnt_q == CNT_MAX);
        Done    = done_q;
    end

endmodule

// File: tb/tb_shift_reg_univ.sv
// Testbench for shift_reg_univ (WIDTH=8, RESET_VAL=0). It runs directed scenarios
// plus a randomized run, and compares against a behavioural model.
module tb_shift_reg_univ;

    localparam int W = 8;
    localparam logic [W-1:0] RV = 8'h00;

    logic         CLK;
    logic         Reset;
    logic         En;
    logic [1:0]   Mode;
    logic [W-1:0] D;
    logic         SerMSB;
    logic         SerLSB;
    logic [W-1:0] Q;
    logic [W-1:0] Qbar;
    logic         SoutLSB;
    logic         SoutMSB;
    logic         Full;
    logic         Done;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model state
    logic [W-1:0] m_q;
    int           m_cnt;
    bit           m_done;

    shift_reg_univ #(.WIDTH(W), .RESET_VAL(RV)) dut (
        .CLK(CLK), .Reset(Reset), .En(En), .Mode(Mode), .D(D),
        .SerMSB(SerMSB), .SerLSB(SerLSB), .Q(Q), .Qbar(Qbar),
        .SoutLSB(SoutLSB), .SoutMSB(SoutMSB), .Full(Full), .Done(Done)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [2*W+3:0] exp_vec();
        return {m_q, ~m_q, m_q[0], m_q[W-1], (m_cnt == W), m_done};
    endfunction

    function automatic logic [2*W+3:0] got_vec();
        return {Q, Qbar, SoutLSB, SoutMSB, Full, Done};
    endfunction

    // Drive one cycle of inputs, clock it, update the model, then settle past the edge
    task automatic apply(input bit rst, input bit en, input logic [1:0] mode,
                         input logic [W-1:0] d, input bit sm, input bit sl);
        bit in_m, in_l;
        Reset = rst; En = en; Mode = mode; D = d; SerMSB = sm; SerLSB = sl;
        @(posedge CLK);
`ifdef SHREG_ROTATE_EN
        in_m = m_q[0];
        in_l = m_q[W-1];
`else
        in_m = sm;
        in_l = sl;
`endif
        if (rst) begin
            m_q = RV; m_cnt = 0; m_done = 0;
        end else if (!en || mode == 2'b00) begin
            m_done = 0;
        end else if (mode == 2'b11) begin
            m_q = d; m_cnt = 0; m_done = 0;
        end else begin
            m_done = (m_cnt == W - 1);
            m_cnt  = (m_cnt + 1 > W) ? W : m_cnt + 1;
            if (mode == 2'b01) m_q = (m_q >> 1) | (W'(in_m) << (W - 1));
            else               m_q = (m_q << 1) | W'(in_l);
        end
        #1;
    endtask

    task automatic test_reset();
        apply(1, 1, 2'b11, 8'hFF, 0, 0);
        n_cmp++;
        if (Q !== 8'h00 || Qbar !== 8'hFF || Full !== 1'b0 || Done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_wins: Q=%h Qbar=%h Full=%b Done=%b, want 00 FF 0 0", Q, Qbar, Full, Done);
        end
        apply(0, 0, 2'b00, 8'h00, 0, 0);
        n_cmp++;
        if (got_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL reset_hold: got %h want %h", got_vec(), exp_vec());
        end
    endtask

    task automatic test_shift_right();
        logic [7:0] seq;
        int pulses;
        seq = 8'b10100101;
        pulses = 0;
        apply(0, 1, 2'b11, 8'hA5, 0, 0);
        for (int i = 0; i < W; i++) begin
            n_cmp++;
            if (SoutLSB !== seq[7-i]) begin
                n_err++;
                $display("FAIL sout_lsb_seq[%0d]: got %b want %b", i, SoutLSB, seq[7-i]);
            end
            apply(0, 1, 2'b01, 8'h00, 0, 0);
            if (Done) pulses++;
            n_cmp++;
            if (Done !== (i == W - 1)) begin
                n_err++;
                $display("FAIL right_done[%0d]: got %b want %b", i, Done, (i == W - 1));
            end
        end
        n_cmp++;
        if (Q !== 8'h00 || Full !== 1'b1 || pulses != 1) begin
            n_err++;
            $display("FAIL right_final: Q=%h Full=%b pulses=%0d, want 00 1 1", Q, Full, pulses);
        end
    endtask

    task automatic test_shift_left_enable();
        apply(0, 1, 2'b11, 8'h81, 0, 0);
        apply(0, 1, 2'b10, 8'h00, 0, 1);
        n_cmp++;
        if (Q !== 8'h03 || SoutMSB !== 1'b0) begin
            n_err++;
            $display("FAIL left_shift: Q=%h SoutMSB=%b, want 03 0", Q, SoutMSB);
        end
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 2'($urandom_range(0, 3)), 8'($urandom), 1, 1);
            n_cmp++;
            if (Q !== 8'h03 || got_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL en_hold[%0d]: Q=%h got %h want %h", i, Q, got_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        pulses = 0;
        apply(0, 1, 2'b11, 8'h0F, 0, 0);
        for (int i = 0; i < 5; i++) begin
            apply(0, 1, 2'($urandom_range(1, 2)), 8'h00, 1'($urandom), 1'($urandom));
            if (Done) pulses++;
        end
        apply(1, 1, 2'b01, 8'h00, 0, 0);
        if (Done) pulses++;
        for (int i = 0; i < W; i++) begin
            apply(0, 1, 2'b01, 8'h00, 1'($urandom), 0);
            if (Done) pulses++;
            n_cmp++;
            if (Done !== (i == W - 1) || Full !== (i == W - 1)) begin
                n_err++;
                $display("FAIL post_reset[%0d]: Done=%b Full=%b want %b", i, Done, Full, (i == W - 1));
            end
        end
        n_cmp++;
        if (pulses != 1) begin
            n_err++;
            $display("FAIL post_reset_pulses: got %0d want 1", pulses);
        end
        apply(0, 1, 2'b10, 8'h00, 0, 1);
        n_cmp++;
        if (Full !== 1'b1 || Done !== 1'b0) begin
            n_err++;
            $display("FAIL saturated: Full=%b Done=%b, want 1 0", Full, Done);
        end
        apply(0, 1, 2'b11, 8'h3C, 0, 0);
        n_cmp++;
        if (Full !== 1'b0 || Q !== 8'h3C) begin
            n_err++;
            $display("FAIL load_clears: Full=%b Q=%h, want 0 3C", Full, Q);
        end
    endtask

    task automatic test_mixed();
        int shifts;
        shifts = 0;
        apply(0, 1, 2'b11, 8'h0F, 0, 0);
        while (shifts < W) begin
            if ($urandom_range(0, 2) == 0) begin
                apply(0, 1, 2'b00, 8'h00, 1, 1);
            end else begin
                apply(0, 1, (shifts < 4) ? 2'b01 : 2'b10, 8'h00, 1'($urandom), 1'($urandom));
                shifts++;
            end
            n_cmp++;
            if (got_vec() !== exp_vec() || Done !== (shifts == W && Mode != 2'b00)) begin
                n_err++;
                $display("FAIL mixed[%0d]: got %h want %h", shifts, got_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int i = 0; i < 400; i++) begin
            apply(($urandom_range(0, 40) == 0), ($urandom_range(0, 4) != 0),
                  2'($urandom_range(0, 3) == 3 && $urandom_range(0, 3) != 0 ? 0 : $urandom_range(0, 3)),
                  8'($urandom), 1'($urandom), 1'($urandom));
            n_cmp++;
            if (got_vec() !== exp_vec()) begin
                n_err++;
                errs++;
                if (errs < 10) $display("FAIL random[%0d]: got %h want %h", i, got_vec(), exp_vec());
            end
        end
    endtask

`ifdef SHREG_ROTATE_EN
    task automatic test_rotate();
        apply(0, 1, 2'b11, 8'h81, 0, 0);
        apply(0, 1, 2'b01, 8'h00, 0, 0);
        n_cmp++;
        if (Q !== 8'hC0) begin
            n_err++;
            $display("FAIL rotate_one: Q=%h want C0", Q);
        end
        apply(0, 1, 2'b11, 8'h81, 0, 0);
        for (int i = 0; i < W; i++) apply(0, 1, 2'b01, 8'h00, 0, 0);
        n_cmp++;
        if (Q !== 8'h81 || Done !== 1'b1) begin
            n_err++;
            $display("FAIL rotate_full: Q=%h Done=%b want 81 1", Q, Done);
        end
    endtask
`endif

    initial begin
        Reset = 1'b0; En = 1'b0; Mode = 2'b00; D = '0; SerMSB = 1'b0; SerLSB = 1'b0;
        m_q = RV; m_cnt = 0; m_done = 0;
        #2;
        test_reset();
        test_shift_right();
        test_shift_left_enable();
        test_reset_mid();
        test_mixed();
        test_random();
`ifdef SHREG_ROTATE_EN
        test_rotate();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
